z3_slave_ctrl: RTL and testbench
================================

# z3_slave_ctrl

Parametrised Zorro III slave cycle controller, the next generation of the single-window IDLE/START/DATA/END slave sequencer in the A4092 top level. It synchronises FCS_n and DS_n, latches the address, and decodes it against NUM_TARGETS programmable windows. It then runs the slave handshake toward whichever internal target is selected. It adds a wait-state timeout that terminates hung cycles with a bus error, and optional Zorro III multiple-transfer support.

## Interface
- NUM_TARGETS, 4: number of decode windows / target channels (1..8).
- SYNC_STAGES, 2: synchroniser depth for FCS_n and DS_n (>=2).
- TIMEOUT_CYCLES, 64: maximum CLK cycles spent in DATA before a forced error termination (>=2).
- MULTI_EN, 0: 1 enables multiple-transfer (burst) beats within one FCS_n assertion.
- CLK  in  1  system clock; all state on rising edge.
- IORST_n  in  1  asynchronous active-low reset.
- FCS_n  in  1  raw full-cycle strobe, active low.
- DS_n  in  4  raw data strobes, active low.
- READ, DOE  in  1 each  bus direction / data output enable.
- FC  in  3  function code; the cycle is valid when FC[1]^FC[0].
- A  in  24  bus address bits [31:8].
- A_LO  in  6  bus address bits [7:2], resampled each beat.
- tgt_base  in  16*NUM_TARGETS  per-target base for A[31:16].
- tgt_mask  in  16*NUM_TARGETS  per-target compare mask (1 = compared).
- tgt_en  in  NUM_TARGETS  window enable (e.g. configured).
- tgt_ack  in  NUM_TARGETS  per-target done pulse/level.
- sel  out  NUM_TARGETS  one-hot selected target, valid START..END.
- addr_lat  out  30  latched {A[31:8], A_LO}.
- dtack  out  1  cycle acknowledge (active high; pad inversion external).
- berr  out  1  timeout bus error.
- mtack  out  1  multiple-transfer capable indication.
- busy  out  1  state != IDLE.

## Operation
- Synchronisers: fcs_s and ds_s are the SYNC_STAGES-deep flop chains, reset to all-ones.
- Decode: hit[i] = tgt_en[i] && ((A[31:16] ^ base_i) & mask_i) == 0. Lowest index wins when several hit.
- IDLE: dtack=berr=0, sel=0. When fcs_s low && |hit && validspace: latch addr_lat, set sel one-hot, go to START. Otherwise stay in IDLE.
- START: go to IDLE if fcs_s high. Otherwise go to DATA if READ or (any ds_s low && DOE). The timeout counter clears on entry.
- DATA: go to IDLE if fcs_s high. On tgt_ack[selected], go to END and set dtack=1. If the counter reaches TIMEOUT_CYCLES-1 without ack, go to END and set berr=1, with dtack held 0. The counter is $clog2(TIMEOUT_CYCLES) bits and saturates; it never wraps.
- END: hold dtack/berr. When fcs_s goes high: go to IDLE and clear dtack, berr and sel on the same edge.
- Multiple transfer, MULTI_EN=1 only: in END, all ds_s high while fcs_s is still low makes the controller clear dtack, relatch A_LO into addr_lat[5:0], keep sel, and go to START. The next beat then reuses the decode. berr is never cleared by a beat; an errored cycle waits for fcs_s high.
- mtack = MULTI_EN && state != IDLE; a constant 0 when MULTI_EN=0.
- tgt_ack on a non-selected channel is ignored. Simultaneous ack and timeout on the same edge: ack wins, so dtack=1 and berr=0.

## Timing
- Reset (asynchronous, any state): state IDLE, sel=0, addr_lat=0, dtack=0, berr=0, mtack=0, busy=0, counter 0, synchronisers all-ones.
- FCS_n falling to sel/busy high: SYNC_STAGES+1 edges.
- START to DATA: 1 edge after the qualifying READ/DS condition is seen on the synchronised strobes.
- tgt_ack high at edge k while in DATA: dtack high after edge k.
- Timeout: berr high exactly TIMEOUT_CYCLES edges after entering DATA.
- FCS_n rising to dtack low / IDLE: SYNC_STAGES+1 edges.
- Abort: fcs_s high in START or DATA returns to IDLE with no dtack/berr pulse.
- Back-to-back cycles need at least one IDLE cycle between them.

## Test plan
- Read hit: target 1 base 0x4000 mask 0xF000, A=0x412345, READ=1, ack 3 cycles after DATA. Required: sel=0b0010, dtack 1 edge after ack, dtack low SYNC_STAGES+1 edges after FCS_n high.
- Priority/miss: targets 0 and 2 both match 0xFF00xx, so sel=0b0001. Then A=0x200000 with no window matching: the controller stays in IDLE and dtack is never asserted.
- Timeout: TIMEOUT_CYCLES=8 with no ack. Required: berr=1 eight edges after entering DATA, dtack=0, berr clears after FCS_n high. A separate case drives ack on the timeout edge: dtack=1, berr=0.
- Write gating: READ=0, DS_n=0b0000 with DOE=0. The controller stays in START; raising DOE moves it to DATA on the next edge.
- Burst, MULTI_EN=1: 4 beats with A_LO=0,1,2,3 and DS_n toggling while FCS_n is held low. Required: 4 dtack pulses, addr_lat[5:0] following A_LO, sel constant, mtack=1 throughout.
- Reset mid-DATA, and FCS_n abort in START: IORST_n low forces all outputs 0 immediately. An abort in START produces no dtack.

Source files
------------

// File: rtl/z3_slave_ctrl_if.sv
// z3_slave_ctrl_if
//   Bundles the Zorro III slave-side bus signals, the decode window
//   configuration and the per-target handshake of z3_slave_ctrl.
//   slave  : the controller (bus/config/ack in, select/ack/status out)
//   master : the bus + target side that drives the controller
//   Bus      : FCS_n, DS_n[3:0], READ, DOE, FC[2:0], A[31:8], A_LO[7:2]
//   Config   : tgt_base, tgt_mask (16 bits per target), tgt_en
//   Targets  : tgt_ack in, sel out
//   Status   : addr_lat[29:0], dtack, berr, mtack, busy
interface z3_slave_ctrl_if #(
  parameter int NUM_TARGETS = 4
);
  logic                      FCS_n;
  logic [3:0]                DS_n;
  logic                      READ;
  logic                      DOE;
  logic [2:0]                FC;
  logic [23:0]               A;
  logic [5:0]                A_LO;
  logic [16*NUM_TARGETS-1:0] tgt_base;
  logic [16*NUM_TARGETS-1:0] tgt_mask;
  logic [NUM_TARGETS-1:0]    tgt_en;
  logic [NUM_TARGETS-1:0]    tgt_ack;
  logic [NUM_TARGETS-1:0]    sel;
  logic [29:0]               addr_lat;
  logic                      dtack;
  logic                      berr;
  logic                      mtack;
  logic                      busy;

  modport slave (
    input  FCS_n, DS_n, READ, DOE, FC, A, A_LO,
    input  tgt_base, tgt_mask, tgt_en, tgt_ack,
    output sel, addr_lat, dtack, berr, mtack, busy
  );

  modport master (
    output FCS_n, DS_n, READ, DOE, FC, A, A_LO,
    output tgt_base, tgt_mask, tgt_en, tgt_ack,
    input  sel, addr_lat, dtack, berr, mtack, busy
  );
endinterface

// File: rtl/z3_slave_ctrl.sv
// z3_slave_ctrl
//   Zorro III slave cycle controller: synchronises FCS_n/DS_n, decodes the
//   address against NUM_TARGETS windows, runs the slave handshake toward the
//   selected target, ends hung cycles with berr after TIMEOUT_CYCLES in DATA,
//   and optionally supports multiple-transfer beats (MULTI_EN=1).
//   CLK     : system clock, rising edge
//   IORST_n : asynchronous active-low reset
//   bus     : z3_slave_ctrl_if.slave (bus strobes/address, window config,
//             tgt_ack in; sel, addr_lat, dtack, berr, mtack, busy out)
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | no cycle; waiting for FCS with a window hit in a valid space
//   ST_START | target selected, address latched; waiting for READ or DS+DOE
//   ST_DATA  | waiting for the selected target's ack, timeout running
//   ST_END   | dtack or berr held until FCS rises (or next beat starts)
module z3_slave_ctrl #(
  parameter int NUM_TARGETS    = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MULTI_EN       = 0
) (
  input  logic           CLK,
  input  logic           IORST_n,
  z3_slave_ctrl_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_END} state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_TARGETS-1:0] r_sel, w_sel_nxt;
  logic [29:0]            r_addr_lat, w_addr_nxt;
  logic                   r_dtack, w_dtack_nxt;
  logic                   r_berr, w_berr_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;

  logic [SYNC_STAGES-1:0] r_fcs_sync;
  logic [3:0]             r_ds_sync [SYNC_STAGES];
  logic                   w_fcs_s;
  logic [3:0]             w_ds_s;
  logic [NUM_TARGETS-1:0] w_hit_sel;
  logic                   w_valid_space;
  logic                   w_ack;
  logic                   w_unused_fc;

  // Strobe synchronisers idle at all-ones so reset looks like "no cycle".
  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      r_fcs_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) r_ds_sync[i] <= 4'hF;
    end else begin
      r_fcs_sync   <= {r_fcs_sync[SYNC_STAGES-2:0], bus.FCS_n};
      r_ds_sync[0] <= bus.DS_n;
      for (int i = 1; i < SYNC_STAGES; i++) r_ds_sync[i] <= r_ds_sync[i-1];
    end
  end

  assign w_fcs_s = r_fcs_sync[SYNC_STAGES-1];
  assign w_ds_s  = r_ds_sync[SYNC_STAGES-1];

  // Descending scan so the lowest matching window ends up selected.
  always_comb begin
    w_hit_sel = '0;
    for (int i = NUM_TARGETS-1; i >= 0; i--) begin
      if (bus.tgt_en[i] &&
          (((bus.A[23:8] ^ bus.tgt_base[16*i +: 16]) & bus.tgt_mask[16*i +: 16]) == 16'h0)) begin
        w_hit_sel    = '0;
        w_hit_sel[i] = 1'b1;
      end
    end
  end

  assign w_valid_space = bus.FC[1] ^ bus.FC[0];
  assign w_unused_fc   = &{1'b0, bus.FC[2]};
  assign w_ack         = |(bus.tgt_ack & r_sel);

  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_addr_lat <= '0;
      r_dtack    <= 1'b0;
      r_berr     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_addr_lat <= w_addr_nxt;
      r_dtack    <= w_dtack_nxt;
      r_berr     <= w_berr_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_addr_nxt  = r_addr_lat;
    w_dtack_nxt = r_dtack;
    w_berr_nxt  = r_berr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_dtack_nxt = 1'b0;
        w_berr_nxt  = 1'b0;
        w_sel_nxt   = '0;
        if (!w_fcs_s && (|w_hit_sel) && w_valid_space) begin
          w_state_nxt = ST_START;
          w_sel_nxt   = w_hit_sel;
          w_addr_nxt  = {bus.A, bus.A_LO};
        end
      end
      ST_START: begin
        w_cnt_nxt = '0;
        if (w_fcs_s) begin
          w_state_nxt = ST_IDLE;
          w_sel_nxt   = '0;
        end else if (bus.READ || (!(&w_ds_s) && bus.DOE)) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_fcs_s) begin
          w_state_nxt = ST_IDLE;
          w_sel_nxt   = '0;
        end else if (w_ack) begin
          // ack is tested first so it wins over a timeout on the same edge
          w_state_nxt = ST_END;
          w_dtack_nxt = 1'b1;
        end else if (r_cnt == CW'(TIMEOUT_CYCLES-1)) begin
          w_state_nxt = ST_END;
          w_berr_nxt  = 1'b1;
        end else if (r_cnt != {CW{1'b1}}) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_END: begin
        if (w_fcs_s) begin
          w_state_nxt = ST_IDLE;
          w_dtack_nxt = 1'b0;
          w_berr_nxt  = 1'b0;
          w_sel_nxt   = '0;
        end else if ((MULTI_EN != 0) && (&w_ds_s) && !r_berr) begin
          // next beat: keep the decode, refresh only the low address bits
          w_state_nxt      = ST_START;
          w_dtack_nxt      = 1'b0;
          w_addr_nxt[5:0]  = bus.A_LO;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.sel      = r_sel;
  assign bus.addr_lat = r_addr_lat;
  assign bus.dtack    = r_dtack;
  assign bus.berr     = r_berr;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.mtack    = (MULTI_EN != 0) && (r_state != ST_IDLE);

endmodule

// File: tb/tb_z3_slave_ctrl.sv
// tb_z3_slave_ctrl
//   Randomised scoreboard bench for z3_slave_ctrl (burst mode, short timeout).
//   Stimulus pushes expected start/termination events; a negedge monitor pops
//   and compares whenever busy rises or dtack/berr rises.
module tb_z3_slave_ctrl;
  localparam int NT = 4;
  localparam int SS = 2;
  localparam int TO = 8;
  localparam int ME = 1;

  logic CLK = 1'b0;
  logic IORST_n = 1'b1;
  always #5 CLK = ~CLK;

  z3_slave_ctrl_if #(.NUM_TARGETS(NT)) bus ();

  z3_slave_ctrl #(
    .NUM_TARGETS(NT), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO), .MULTI_EN(ME)
  ) dut (
    .CLK(CLK), .IORST_n(IORST_n), .bus(bus)
  );

  int total = 0;
  int bad = 0;

  logic [15:0]   cfg_base [NT];
  logic [15:0]   cfg_mask [NT];
  logic [NT-1:0] cfg_en;

  typedef struct {
    bit            term;
    logic [NT-1:0] sel;
    logic [29:0]   addr;
    bit            dtack;
    bit            berr;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lowest-numbered enabled window whose compared bits equal A[31:16].
  function automatic logic [NT-1:0] ref_sel(input logic [23:0] a, input logic [2:0] fc);
    logic [NT-1:0] r;
    r = '0;
    if (fc[1] == fc[0]) return r;
    for (int i = 0; i < NT; i++) begin
      if (cfg_en[i] && (((a[23:8] ^ cfg_base[i]) & cfg_mask[i]) == 16'h0)) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic apply_cfg();
    for (int i = 0; i < NT; i++) begin
      bus.tgt_base[16*i +: 16] = cfg_base[i];
      bus.tgt_mask[16*i +: 16] = cfg_mask[i];
    end
    bus.tgt_en = cfg_en;
  endtask

  task automatic push(input bit term, input logic [NT-1:0] s, input logic [29:0] ad,
                      input bit dt, input bit be);
    exp_t e;
    e.term = term; e.sel = s; e.addr = ad; e.dtack = dt; e.berr = be;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input bit term);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_unexpected: got %s event, want none at %0t",
               term ? "termination" : "start", $time);
      return;
    end
    e = sb_q.pop_front();
    check("sb_kind", term, e.term);
    check("sb_sel", bus.sel, e.sel);
    check("sb_addr", bus.addr_lat, e.addr);
    if (term) begin
      check("sb_dtack", bus.dtack, e.dtack);
      check("sb_berr", bus.berr, e.berr);
      check("sb_mtack", bus.mtack, 64'(ME));
    end
  endtask

  initial begin
    bit prev_busy, prev_term;
    prev_busy = 0;
    prev_term = 0;
    forever begin
      @(negedge CLK);
      if (IORST_n) begin
        if (bus.busy && !prev_busy) sb_pop(1'b0);
        if ((bus.dtack || bus.berr) && !prev_term) sb_pop(1'b1);
      end
      prev_busy = bus.busy;
      prev_term = bus.dtack | bus.berr;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_ack(input logic [NT-1:0] s, input bit on);
    logic [NT-1:0] n;
    n = NT'($urandom);
    bus.tgt_ack = (n & ~s) | (on ? s : '0);
  endtask

  task automatic finish_cycle(input bit dt, input bit be);
    bus.FCS_n = 1'b1; bus.DS_n = 4'hF; bus.DOE = 1'b0; bus.tgt_ack = '0;
    repeat (SS) tick();
    check("end_hold", {bus.dtack, bus.berr}, {dt, be});
    tick();
    check("end_release", {bus.dtack, bus.berr, bus.busy, bus.mtack}, 4'b0000);
    check("end_sel", bus.sel, '0);
    tick();
  endtask

  // g: edges DOE is held low in START (writes only); d: ack delay after DATA
  // entry (0 = no ack).
  task automatic run_cycle(input logic [23:0] a, input logic [5:0] alo, input logic [2:0] fc,
                           input bit rd, input int g, input int d);
    logic [NT-1:0] s;
    int E, t, h;
    bit dt;
    s = ref_sel(a, fc);
    bus.A = a; bus.A_LO = alo; bus.FC = fc; bus.READ = rd;
    bus.DS_n = 4'h0; bus.DOE = (g == 0); bus.FCS_n = 1'b0;
    if (s == '0) begin
      for (int e = 1; e <= 8; e++) begin
        tick();
        drive_ack(s, 1'b0);
        check("miss_idle", {bus.busy, bus.dtack, bus.berr}, 3'b000);
      end
      bus.FCS_n = 1'b1; bus.DS_n = 4'hF; bus.DOE = 1'b0; bus.tgt_ack = '0;
      repeat (SS + 2) tick();
      return;
    end
    E  = SS + 2 + g;
    dt = (d >= 1 && d <= TO);
    t  = dt ? E + d : E + TO;
    push(1'b0, s, {a, alo}, 1'b0, 1'b0);
    push(1'b1, s, {a, alo}, dt, !dt);
    h = $urandom_range(0, 3);
    for (int e = 1; e <= t + h; e++) begin
      tick();
      if (e == SS) check("pre_start_busy", bus.busy, 0);
      if (e == SS + 1) begin
        check("start_busy", bus.busy, 1);
        check("start_sel", bus.sel, s);
      end
      if (g > 0 && e == SS + 1 + g) bus.DOE = 1'b1;
      if (e == t - 1) check("pre_term", {bus.dtack, bus.berr}, 2'b00);
      if (e == t) check("term", {bus.dtack, bus.berr}, {dt, !dt});
      drive_ack(s, d >= 1 && e == E + d - 1);
    end
    finish_cycle(dt, !dt);
  endtask

  task automatic burst(input logic [23:0] a, input logic [5:0] alo0, input int nb,
                       input bit err_last);
    logic [NT-1:0] s;
    logic [5:0] alo;
    int E, t, d, e;
    bit dt;
    s = ref_sel(a, 3'b001);
    alo = alo0;
    dt = 1'b1;
    bus.A = a; bus.A_LO = alo; bus.FC = 3'b001; bus.READ = 1'b1;
    bus.DS_n = 4'h0; bus.DOE = 1'b0; bus.FCS_n = 1'b0;
    push(1'b0, s, {a, alo}, 1'b0, 1'b0);
    E = SS + 2;
    e = 0;
    for (int b = 0; b < nb; b++) begin
      d  = (err_last && b == nb - 1) ? 0 : $urandom_range(1, 3);
      dt = (d != 0);
      t  = dt ? E + d : E + TO;
      push(1'b1, s, {a, alo}, dt, !dt);
      while (e < t) begin
        tick();
        e++;
        drive_ack(s, dt && e == E + d - 1);
      end
      check("beat_term", {bus.dtack, bus.berr}, {dt, !dt});
      check("beat_sel", bus.sel, s);
      check("beat_mtack", bus.mtack, 1);
      if (b < nb - 1) begin
        alo = alo + 6'd1;
        bus.DS_n = 4'hF;
        bus.A_LO = alo;
        repeat (SS) begin tick(); e++; drive_ack(s, 1'b0); end
        check("beat_hold", bus.dtack, 1);
        tick(); e++; drive_ack(s, 1'b0);
        check("beat_restart", {bus.dtack, bus.busy, bus.mtack}, 3'b011);
        check("beat_alo", bus.addr_lat[5:0], alo);
        check("beat_keep_sel", bus.sel, s);
        bus.DS_n = 4'h0;
        E = e + 1;
      end
    end
    if (err_last) begin
      bus.DS_n = 4'hF;
      repeat (SS + 3) begin tick(); drive_ack(s, 1'b0); end
      check("err_no_beat", {bus.dtack, bus.berr}, 2'b01);
    end
    finish_cycle(dt, !dt);
  endtask

  task automatic abort_cycle(input logic [23:0] a, input bit rd);
    logic [NT-1:0] s;
    s = ref_sel(a, 3'b001);
    bus.A = a; bus.A_LO = 6'h15; bus.FC = 3'b001; bus.READ = rd;
    bus.DS_n = 4'h0; bus.DOE = 1'b0; bus.FCS_n = 1'b0;
    push(1'b0, s, {a, 6'h15}, 1'b0, 1'b0);
    repeat (SS + 4) begin tick(); drive_ack(s, 1'b0); end
    bus.FCS_n = 1'b1; bus.DS_n = 4'hF;
    repeat (SS) begin tick(); drive_ack(s, 1'b0); end
    check("abort_hold", {bus.busy, bus.dtack, bus.berr}, 3'b100);
    tick();
    bus.tgt_ack = '0;
    check("abort_idle", {bus.busy, bus.dtack, bus.berr}, 3'b000);
    check("abort_sel", bus.sel, '0);
    tick();
  endtask

  task automatic reset_mid_data();
    logic [NT-1:0] s;
    s = ref_sel(24'h412345, 3'b001);
    bus.A = 24'h412345; bus.A_LO = 6'h07; bus.FC = 3'b001; bus.READ = 1'b1;
    bus.DS_n = 4'h0; bus.DOE = 1'b0; bus.FCS_n = 1'b0;
    push(1'b0, s, {24'h412345, 6'h07}, 1'b0, 1'b0);
    repeat (SS + 4) begin tick(); drive_ack(s, 1'b0); end
    check("rst_pre_busy", bus.busy, 1);
    #2 IORST_n = 1'b0;
    #1 check("rst_async", {bus.sel, bus.addr_lat, bus.dtack, bus.berr, bus.mtack, bus.busy}, '0);
    bus.FCS_n = 1'b1; bus.DS_n = 4'hF; bus.READ = 1'b0; bus.tgt_ack = '0;
    tick(); tick();
    check("rst_held", {bus.busy, bus.dtack, bus.berr}, 3'b000);
    @(negedge CLK);
    IORST_n = 1'b1;
    tick(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, want completion before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_base[0] = 16'hFF00; cfg_mask[0] = 16'hFF00;
    cfg_base[1] = 16'h4000; cfg_mask[1] = 16'hF000;
    cfg_base[2] = 16'hFF00; cfg_mask[2] = 16'hFFFF;
    cfg_base[3] = 16'h8000; cfg_mask[3] = 16'hC000;
    cfg_en = 4'b1111;
    apply_cfg();
    bus.FCS_n = 1'b1; bus.DS_n = 4'hF; bus.READ = 1'b0; bus.DOE = 1'b0;
    bus.FC = 3'b001; bus.A = '0; bus.A_LO = '0; bus.tgt_ack = '0;

    #2 IORST_n = 1'b0;
    #1 check("reset_outputs", {bus.sel, bus.addr_lat, bus.dtack, bus.berr, bus.mtack, bus.busy}, '0);
    tick(); tick();
    check("reset_held", {bus.sel, bus.dtack, bus.berr, bus.mtack, bus.busy}, '0);
    @(negedge CLK);
    IORST_n = 1'b1;
    tick(); tick();
    check("idle_after_reset", {bus.busy, bus.dtack, bus.berr}, 3'b000);

    run_cycle(24'h412345, 6'h2A, 3'b001, 1'b1, 0, 3);
    run_cycle(24'hFF0012, 6'h01, 3'b001, 1'b1, 0, 2);
    run_cycle(24'h200000, 6'h00, 3'b001, 1'b1, 0, 2);
    run_cycle(24'h8ABCDE, 6'h3F, 3'b001, 1'b1, 0, 0);
    run_cycle(24'h8ABCDE, 6'h11, 3'b001, 1'b1, 0, TO);
    run_cycle(24'h412000, 6'h05, 3'b001, 1'b0, 3, 2);
    run_cycle(24'h4F0000, 6'h06, 3'b010, 1'b0, 0, 1);
    run_cycle(24'h412345, 6'h00, 3'b011, 1'b1, 0, 2);
    burst(24'h4000AA, 6'h00, 4, 1'b0);
    burst(24'hFF0001, 6'h10, 2, 1'b1);
    abort_cycle(24'h412345, 1'b0);
    abort_cycle(24'h8ABCDE, 1'b1);
    reset_mid_data();

    cfg_en = 4'b1110;
    apply_cfg();
    run_cycle(24'hFF0034, 6'h09, 3'b001, 1'b1, 0, 1);
    cfg_en = 4'b1111;
    apply_cfg();

    for (int it = 0; it < 40; it++) begin
      logic [23:0] a;
      logic [2:0]  fc;
      int cls, g, d;
      bit rd;
      cls = $urandom_range(0, 4);
      case (cls)
        0:       a = {4'h4, 20'($urandom)};
        1:       a = {16'hFF00, 8'($urandom)};
        2:       a = {2'b10, 22'($urandom)};
        default: a = 24'($urandom);
      endcase
      fc = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b001;
      if (ref_sel(a, 3'b001) != '0 && $urandom_range(0, 3) == 0) begin
        burst(a, 6'($urandom), $urandom_range(2, 4), 1'($urandom_range(0, 1)));
      end else begin
        rd = 1'($urandom_range(0, 1));
        g  = rd ? 0 : $urandom_range(0, 3);
        d  = $urandom_range(0, TO + 2);
        run_cycle(a, 6'($urandom), fc, rd, g, d);
      end
    end

    repeat (4) tick();
    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
